// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown operator front end.
// Holds the FSM state type, the preset range/default constants, the
// 100 MHz debounce and auto-repeat timings, and small preset wrap helpers.
package countdown_pkg;

  // state | meaning
  // SET   | operator edits the preset; confirm arms the controller
  // ARM   | start held high, waiting for the controller to report counting
  // RUN   | controller counting; stop aborts, done/counting-low returns to SET
  typedef enum logic [1:0] {
    ST_SET = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_TIME_C    = 10;
  localparam int unsigned MAX_TIME_C        = 99;
  localparam int unsigned DEBOUNCE_CYCLES_C = 2_000_000;   // 20 ms
  localparam int unsigned REPEAT_DELAY_C    = 50_000_000;  // 500 ms
  localparam int unsigned REPEAT_PERIOD_C   = 20_000_000;  // 200 ms

  localparam int TIME_W = 8;

  // Step up with wrap to 0 past the maximum.
  function automatic logic [TIME_W-1:0] time_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    return (v >= max_v) ? '0 : v + TIME_W'(1);
  endfunction

  // Step down with wrap to the maximum below 0.
  function automatic logic [TIME_W-1:0] time_dec(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    return (v == '0) ? max_v : v - TIME_W'(1);
  endfunction

endpackage

// File: rtl/countdown_setter_if.sv
// Signal bundle between the board buttons / countdown controller and the
// countdown_setter front end.
//   btn_*          raw active-high buttons (asynchronous)
//   counting, done status from the countdown controller
//   countdown_time preset value, start, end_timer, editing: setter outputs
// master: the side driving buttons and controller status.
// slave : the countdown_setter itself.
interface countdown_setter_if;
  import countdown_pkg::*;

  logic              btn_up;
  logic              btn_down;
  logic              btn_confirm;
  logic              btn_stop;
  logic              counting;
  logic              done;
  logic [TIME_W-1:0] countdown_time;
  logic              start;
  logic              end_timer;
  logic              editing;

  modport master (
    output btn_up, btn_down, btn_confirm, btn_stop, counting, done,
    input  countdown_time, start, end_timer, editing
  );

  modport slave (
    input  btn_up, btn_down, btn_confirm, btn_stop, counting, done,
    output countdown_time, start, end_timer, editing
  );

endinterface

// File: rtl/countdown_setter_btn_debounce.sv
// Single-button conditioner: 2-FF synchronizer, stability down-counter,
// registered debounced level and a one-cycle press pulse on its rising edge.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   btn_i       raw button (asynchronous)
//   level_o     debounced level
//   press_o     one-cycle pulse when level_o rises
// The level flips only after DEBOUNCE_CYCLES consecutive synchronized samples
// disagree with it; press_o rises together with level_o.
module btn_debounce
  import countdown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_C
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // cnt_q counts down the samples still needed to accept a new level; it
  // reloads whenever the synchronized input agrees with the current level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      level_d = sync_q[1];
      press_d = sync_q[1];
      cnt_d   = RELOAD;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= RELOAD;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/countdown_setter.sv
// Operator front end for the countdown controller: debounces up/down/
// confirm/stop, edits the preset in SET, raises start in ARM and issues a
// one-cycle end_timer abort from RUN.
// Ports:
//   clk, rst_n  100 MHz clock / async active-low reset
//   bus         countdown_setter_if.slave (buttons, controller status,
//               countdown_time, start, end_timer, editing)
// Build option: COUNTDOWN_AUTO_REPEAT_EN adds hold-to-repeat on up/down
// (first step at the press, next after REPEAT_DELAY, then every
// REPEAT_PERIOD). Without it each press gives exactly one step.
// All outputs come straight from flops.
module countdown_setter
  import countdown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_C,
  parameter int unsigned MAX_TIME        = MAX_TIME_C,
  parameter int unsigned DEFAULT_TIME    = DEFAULT_TIME_C,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_C,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_C
) (
  input  logic              clk,
  input  logic              rst_n,
  countdown_setter_if.slave bus
);

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] DEF_T = TIME_W'(DEFAULT_TIME);

  logic lvl_up, lvl_down, lvl_confirm, lvl_stop;
  logic prs_up, prs_down, prs_confirm, prs_stop;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_up),
    .level_o(lvl_up), .press_o(prs_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_down),
    .level_o(lvl_down), .press_o(prs_down)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_confirm),
    .level_o(lvl_confirm), .press_o(prs_confirm)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_stop),
    .level_o(lvl_stop), .press_o(prs_stop)
  );

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              editing_q, editing_d;

  logic up_ev, down_ev;

  // Only the up/down levels are needed, and only for auto-repeat.
  logic unused_levels;
  assign unused_levels = lvl_confirm ^ lvl_stop;

`ifdef COUNTDOWN_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  // index 0 = up, 1 = down
  logic [1:0][RPT_W-1:0] rpt_q, rpt_d;
  logic [1:0]            act_q, act_d;
  logic [1:0]            rpt_step;
  logic [1:0]            held, pressed;

  assign held    = {lvl_down, lvl_up};
  assign pressed = {prs_down, prs_up};

  // The press itself is the first step; the counter is loaded then and
  // produces further steps on its terminal count while the button is held.
  always_comb begin
    rpt_d    = rpt_q;
    act_d    = act_q;
    rpt_step = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (state_q != ST_SET || !held[i]) begin
        rpt_d[i] = '0;
        act_d[i] = 1'b0;
      end else if (pressed[i]) begin
        rpt_d[i] = DELAY_LOAD;
        act_d[i] = 1'b1;
      end else if (act_q[i]) begin
        if (rpt_q[i] == '0) begin
          rpt_step[i] = 1'b1;
          rpt_d[i]    = PERIOD_LOAD;
        end else begin
          rpt_d[i] = rpt_q[i] - RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '0;
      act_q <= 2'b00;
    end else begin
      rpt_q <= rpt_d;
      act_q <= act_d;
    end
  end

  assign up_ev   = prs_up   | rpt_step[0];
  assign down_ev = prs_down | rpt_step[1];
`else
  logic unused_repeat;
  assign unused_repeat = lvl_up ^ lvl_down ^ (^32'(REPEAT_DELAY)) ^ (^32'(REPEAT_PERIOD));

  assign up_ev   = prs_up;
  assign down_ev = prs_down;
`endif

  // Edits act only in SET, so the preset is frozen in ARM and RUN.
  // In ARM a stop wins over counting so an abandoned arm never reaches RUN.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    case (state_q)
      ST_SET: begin
        if (up_ev && !down_ev) begin
          time_d = time_inc(time_q, MAX_T);
        end else if (down_ev && !up_ev) begin
          time_d = time_dec(time_q, MAX_T);
        end
        if (prs_confirm && time_q != '0) begin
          state_d = ST_ARM;
          start_d = 1'b1;
        end
      end
      ST_ARM: begin
        start_d = 1'b1;
        if (prs_stop) begin
          state_d = ST_SET;
          start_d = 1'b0;
        end else if (bus.counting) begin
          state_d = ST_RUN;
          start_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (prs_stop) begin
          state_d = ST_SET;
          end_d   = 1'b1;
        end else if (bus.done || !bus.counting) begin
          state_d = ST_SET;
        end
      end
      default: begin
        state_d = ST_SET;
      end
    endcase
    editing_d = (state_d == ST_SET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SET;
      time_q    <= DEF_T;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      editing_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      start_q   <= start_d;
      end_q     <= end_d;
      editing_q <= editing_d;
    end
  end

  assign bus.countdown_time = time_q;
  assign bus.start          = start_q;
  assign bus.end_timer      = end_q;
  assign bus.editing        = editing_q;

endmodule
